// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer: FSM state encoding and address width.
package scan_pkg;

    localparam int unsigned ADDR_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control and decoder-select bundle between a scan controller (master) and the sequencer (slave).
interface scan_sequencer_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode_cont;
    logic [DWELL_W-1:0] dwell;
    logic               a;
    logic               b;
    logic               busy;
    logic               step;
    logic               done;

    modport master (
        output start, stop, mode_cont, dwell,
        input  a, b, busy, step, done
    );

    modport slave (
        input  start, stop, mode_cont, dwell,
        output a, b, busy, step, done
    );
endinterface

// File: rtl/decoder2X4.sv
// 2-to-4 one-hot decoder; a is the select MSB.
module decoder2X4 (
    input  logic a,
    input  logic b,
    output logic f0,
    output logic f1,
    output logic f2,
    output logic f3
);
    assign f0 = ~a & ~b;
    assign f1 = ~a &  b;
    assign f2 =  a & ~b;
    assign f3 =  a &  b;
endmodule

// File: rtl/scan_dwell_cnt.sv
// Dwell down-counter: load captures the hold value, run decrements to zero then reloads it.
module scan_dwell_cnt #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               run,
    output logic               zero_c
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] rld_q, rld_d;

    always_comb begin
        cnt_d = cnt_q;
        rld_d = rld_q;
        if (load) begin
            cnt_d = load_val;
            rld_d = load_val;
        end else if (run) begin
            cnt_d = (cnt_q != '0) ? cnt_q - DWELL_W'(1) : rld_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            rld_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rld_q <= rld_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 2-bit decoder select through 00..11 with a programmable dwell, in single-sweep or
// continuous mode; all outputs come straight from flops.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    scan_sequencer_if.slave  bus
);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              step_q, step_d;
    logic              done_q, done_d;
    logic              mode_q, mode_d;
    logic              cnt_load;
    logic              cnt_run;
    logic              cnt_zero;

    scan_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (bus.dwell),
        .run      (cnt_run),
        .zero_c   (cnt_zero)
    );

    // Next state; pulses default low so step/done last exactly one cycle.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        mode_d   = mode_q;
        busy_d   = 1'b0;
        step_d   = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_run  = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (bus.start && !bus.stop) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    mode_d   = bus.mode_cont;
                    cnt_load = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end else begin
                    cnt_run = 1'b1;
                    busy_d  = 1'b1;
                    if (cnt_zero) begin
                        if (addr_q == ADDR_LAST && !mode_q) begin
                            state_d = DONE;
                            addr_d  = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                            step_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign bus.a    = addr_q[1];
    assign bus.b    = addr_q[0];
    assign bus.busy = busy_q;
    assign bus.step = step_q;
    assign bus.done = done_q;

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 8, giving the dwell count width in bits.
REQ-002 Port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst, input, 1, reset; asynchronous and active-high.
REQ-004 Port start, input, 1, a pulse that begins a scan; it is sampled only in IDLE.
REQ-005 Port stop, input, 1, a pulse that aborts a scan in progress.
REQ-006 Port mode_cont, input, 1, scan mode: 1 = continuous wrap, 0 = single sweep; sampled at start.
REQ-007 Port dwell, input, DWELL_W, extra hold cycles per address; sampled at start.
REQ-008 Port a, output, 1, select MSB driven to the 2-to-4 decoder's a input.
REQ-009 Port b, output, 1, select LSB driven to the 2-to-4 decoder's b input.
REQ-010 Port busy, output, 1, high while in RUN.
REQ-011 Port step, output, 1, a one-cycle pulse on each address advance.
REQ-012 Port done, output, 1, a one-cycle pulse when a single sweep completes.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 In IDLE, {a,b} SHALL be 00, and busy, step and done SHALL be 0.
REQ-016 IDLE with start=1 and stop=0 SHALL go to RUN on the next edge, with these actions:
- {a,b}=00;
- busy=1;
- capture dwell and mode_cont;
- load the dwell counter with the captured dwell.
REQ-017 IDLE with start=1 and stop=1 in the same cycle SHALL remain in IDLE (stop wins).
REQ-018 In RUN, each address SHALL be held for exactly captured_dwell+1 cycles.
REQ-019 In RUN, the dwell counter SHALL decrement each cycle while nonzero.
REQ-020 In RUN, when the counter is 0, the next edge SHALL advance the address ({a,b}+1, modulo 4), reload the counter, and assert step for that one cycle.
REQ-021 In single mode, with {a,b}=11 and counter 0, the next edge SHALL go to DONE with these actions:
- done=1 for one cycle;
- busy=0;
- {a,b}=00;
- step=0.
REQ-022 DONE SHALL return unconditionally to IDLE on the following edge.
REQ-023 A start pulse present while in DONE SHALL be ignored.
REQ-024 In continuous mode, 11 SHALL wrap to 00 with step asserted, and RUN SHALL continue until stop.
REQ-025 stop=1 in RUN SHALL go to IDLE on the next edge, with {a,b}=00, busy=0, and no done or step pulse, regardless of counter value.
REQ-026 start asserted while in RUN SHALL be ignored.
REQ-027 Changes to dwell or mode_cont during RUN SHALL have no effect until the next start.
REQ-028 With dwell=0, the address SHALL advance every cycle, and step SHALL be high every cycle of RUN except the first.
REQ-029 With dwell at its maximum (2^DWELL_W-1), the hold time SHALL be 2^DWELL_W cycles, with no counter overflow.
REQ-030 A single sweep SHALL take 4*(dwell+1) cycles in RUN, followed by 1 cycle in DONE.

Reset
REQ-031 While rst=1, the block SHALL immediately, without waiting for clk, enter IDLE with:
- {a,b}=00;
- busy=0, step=0, done=0;
- counter=0;
- captured dwell/mode cleared.
REQ-032 Reset asserted mid-RUN SHALL abort without a done pulse.
REQ-033 After rst deasserts, the block SHALL require a new start pulse.

Structure
REQ-034 The FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the address width constant (2) SHALL live in the shared package/include scan_pkg.
REQ-035 The dwell down-counter, with load, decrement and zero flag, SHALL be a sub-module named scan_dwell_cnt, parameterised by DWELL_W.
REQ-036 The top level SHALL contain only the FSM, the address register and the output registers.

Verification
REQ-037 The bench SHALL instantiate scan_sequencer driving a decoder2X4, and check that exactly one of f0..f3 is high every cycle after reset.
REQ-038 Single sweep, dwell=0, mode_cont=0, start at cycle 10:
- {a,b} = 00,01,10,11 on cycles 11-14;
- step high on cycles 12-14;
- done high on cycle 15;
- IDLE on cycle 16.
REQ-039 dwell=3, single mode:
- each address held for 4 cycles;
- done exactly 16 cycles after RUN entry;
- busy high for 16 cycles.
REQ-040 Continuous, dwell=1:
- the 11->00 wrap produces a step pulse;
- stop on cycle 20 after start gives {a,b}=00 and busy=0 on cycle 21, with no done.
REQ-041 Simultaneous events:
- start and stop together in IDLE leave the block idle;
- start during RUN leaves the sequence unchanged;
- dwell changed mid-run to 7 does not alter the current hold of 2.
REQ-042 Async reset asserted mid-RUN, away from any clk edge: outputs go to 00/0 before the next edge; a new start then restarts from 00.
